// File: rtl/ws_log_pkg.sv
// Shared constants for the jitter logger statistics engine: frame layout,
// per-channel record type and the sender-handshake FSM encoding.
package ws_log_pkg;

  localparam int HDR_SZ   = 6;  // p_cnt (4 bytes) + drop_cnt snapshot (2 bytes)
  localparam int CH_SZ    = 6;  // max, min, miss; 2 bytes each
  localparam int OFF_PCNT = 0;
  localparam int OFF_DROP = 4;
  localparam int OFF_MAX  = 0;  // offsets inside one channel record
  localparam int OFF_MIN  = 2;
  localparam int OFF_MISS = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Packed so that max lands in the low bytes: the record shifted right by
  // 8*offset yields the little-endian payload byte directly.
  typedef struct packed {
    logic [15:0] miss;
    logic [15:0] min;
    logic [15:0] max;
  } ch_rec_t;

  // Frame size in bytes; never shorter than 18 so the sender frame is fixed.
  function automatic int p_sz(input int nch);
    return (HDR_SZ + CH_SZ * nch > 18) ? (HDR_SZ + CH_SZ * nch) : 18;
  endfunction

endpackage

// File: rtl/ws_jtr_acc.sv
// One channel of jitter statistics: |ts - tr|, running max/min and a
// saturating missed-edge count. o_* present the accumulators merged with
// the current sample so the top can snapshot a window including its last
// measurement.
module ws_jtr_acc #(
  parameter int Nm = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_st_rdy,
  input  logic          i_win_close,
  input  logic [Nm-1:0] i_ts,
  input  logic [Nm-1:0] i_tr,
  input  logic          i_vld,
  output logic [Nm-1:0] o_max,
  output logic [Nm-1:0] o_min,
  output logic [15:0]   o_miss
);

  logic [Nm-1:0] r_max;
  logic [Nm-1:0] r_min;
  logic [15:0]   r_miss;
  logic [Nm-1:0] w_j;

  assign w_j = (i_ts >= i_tr) ? (i_ts - i_tr) : (i_tr - i_ts);

  // Merge the current sample into the running values.
  always_comb begin
    o_max  = r_max;
    o_min  = r_min;
    o_miss = r_miss;
    if (i_vld) begin
      if (w_j > r_max) o_max = w_j;
      if (w_j < r_min) o_min = w_j;
    end else if (r_miss != 16'hFFFF) begin
      o_miss = r_miss + 16'd1;
    end
  end

  // Accumulate on each measurement; restart from init when the window closes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_max  <= '0;
      r_min  <= '1;
      r_miss <= '0;
    end else if (i_st_rdy) begin
      if (i_win_close) begin
        r_max  <= '0;
        r_min  <= '1;
        r_miss <= '0;
      end else begin
        r_max  <= o_max;
        r_min  <= o_min;
        r_miss <= o_miss;
      end
    end
  end

endmodule

// File: rtl/ws_logger_stats.sv
// N-channel jitter statistics and UDP payload engine. Windows of 2^Npr
// measurements are snapshotted into a shadow frame that the sender reads
// byte by byte through addr/payload.
//
// Sender handshake: start is a one-cycle request raised only in IDLE while
// a frame is pending and udp_rdy is high; the sender then drops udp_rdy
// while busy (BUSY -> DONE) and raises it again when finished (DONE ->
// IDLE). The shadow is frozen from start until IDLE, and windows closing
// in that time (or while a frame is still pending) are counted as drops.
module ws_logger_stats
  import ws_log_pkg::*;
#(
  parameter int Nch = 4,
  parameter int Nm  = 16,
  parameter int Npr = 7,
  parameter int Nsz = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             st_rdy,
  input  logic [Nm-1:0]    tr,
  input  logic [Nch*Nm-1:0] ts,
  input  logic [Nch-1:0]   ts_vld,
  input  logic [31:0]      p_cnt,
  input  logic             udp_rdy,
  input  logic [Nsz-1:0]   addr,
  output logic             start,
  output logic [7:0]       payload,
  output logic [15:0]      drop_cnt,
  output logic             trg_led,
  output logic [1:0]       dbg_state
);

  localparam int PSZ = p_sz(Nch);

  logic [Npr-1:0] r_idx;
  logic           r_pend;
  logic [1:0]     r_state;
  logic [15:0]    r_drop;
  logic           r_trg;
  logic [31:0]    r_sh_pcnt;
  logic [15:0]    r_sh_drop;
  ch_rec_t        r_sh_ch [Nch];

  logic [Nm-1:0]  w_max  [Nch];
  logic [Nm-1:0]  w_min  [Nch];
  logic [15:0]    w_miss [Nch];
  logic           w_close;
  logic           w_drop;
  logic           w_take;
  logic [31:0]    w_a;

  assign w_close = st_rdy & (&r_idx);
  assign w_drop  = w_close & (r_pend | (r_state != ST_IDLE));
  assign w_take  = (r_state == ST_IDLE) & r_pend & udp_rdy;
  assign w_a     = 32'(addr);

  assign start     = w_take;
  assign drop_cnt  = r_drop;
  assign trg_led   = r_trg;
  assign dbg_state = r_state;

  for (genvar g = 0; g < Nch; g++) begin : g_ch
    ws_jtr_acc #(.Nm(Nm)) u_acc (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_st_rdy    (st_rdy),
      .i_win_close (w_close),
      .i_ts        (ts[g*Nm +: Nm]),
      .i_tr        (tr),
      .i_vld       (ts_vld[g]),
      .o_max       (w_max[g]),
      .o_min       (w_min[g]),
      .o_miss      (w_miss[g])
    );
  end

  // Snapshot a finished window into the shadow unless it is being dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh_pcnt <= '0;
      r_sh_drop <= '0;
      for (int k = 0; k < Nch; k++) r_sh_ch[k] <= '0;
    end else if (w_close && !w_drop) begin
      r_sh_pcnt <= p_cnt;
      r_sh_drop <= r_drop;
      for (int k = 0; k < Nch; k++) begin
        r_sh_ch[k].max  <= 16'(w_max[k]);
        r_sh_ch[k].min  <= 16'(w_min[k]);
        r_sh_ch[k].miss <= w_miss[k];
      end
    end
  end

  // Measurement index, pending flag, drop counter, LED and sender FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_pend  <= 1'b0;
      r_state <= ST_IDLE;
      r_drop  <= '0;
      r_trg   <= 1'b0;
    end else begin
      if (st_rdy) r_idx <= r_idx + 1'b1;
      if (w_drop && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
      if (w_close && !w_drop) r_pend <= 1'b1;
      else if (w_take)        r_pend <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_take) begin
          r_state <= ST_BUSY;
          r_trg   <= ~r_trg;
        end
        ST_BUSY: if (!udp_rdy) r_state <= ST_DONE;
        ST_DONE: if (udp_rdy)  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Combinational byte select from the shadow frame; unused bytes read 0.
  always_comb begin
    payload = 8'h00;
    if (w_a < 32'(PSZ)) begin
      if (w_a < 32'(OFF_DROP)) begin
        payload = 8'(r_sh_pcnt >> {w_a[1:0], 3'b000});
      end else if (w_a == 32'(OFF_DROP)) begin
        payload = r_sh_drop[7:0];
      end else if (w_a == 32'(OFF_DROP + 1)) begin
        payload = r_sh_drop[15:8];
      end else begin
        for (int k = 0; k < Nch; k++) begin
          if (w_a >= 32'(HDR_SZ + CH_SZ * k) && w_a < 32'(HDR_SZ + CH_SZ * (k + 1)))
            payload = 8'(r_sh_ch[k] >> (8 * (w_a - 32'(HDR_SZ + CH_SZ * k))));
        end
      end
    end
  end

endmodule

// File: tb/tb_ws_logger_stats.sv
// Directed bench for ws_logger_stats. Instance a: Nch=2, Npr=2 for frame
// content, drops, pending and reset. Instance b: Nch=1, Npr=16 for miss
// counter saturation over a 65536-measurement all-missed window.
module tb_ws_logger_stats;

  logic        clk = 1'b0;
  logic        rst;

  // instance a
  logic        st_rdy_a;
  logic [15:0] tr_a;
  logic [31:0] ts_a;
  logic [1:0]  ts_vld_a;
  logic [31:0] p_cnt_a;
  logic        udp_rdy_a;
  logic [6:0]  addr_a;
  logic        start_a;
  logic [7:0]  payload_a;
  logic [15:0] drop_cnt_a;
  logic        trg_led_a;
  logic [1:0]  dbg_state_a;

  // instance b
  logic        st_rdy_b;
  logic [15:0] tr_b;
  logic [15:0] ts_b;
  logic [0:0]  ts_vld_b;
  logic [31:0] p_cnt_b;
  logic        udp_rdy_b;
  logic [6:0]  addr_b;
  logic        start_b;
  logic [7:0]  payload_b;
  logic [15:0] drop_cnt_b;
  logic        trg_led_b;
  logic [1:0]  dbg_state_b;

  int n_total = 0;
  int n_bad   = 0;
  int n_start = 0;

  // clock / reset block
  always #20 clk = ~clk;

  ws_logger_stats #(.Nch(2), .Nm(16), .Npr(2), .Nsz(7)) dut_a (
    .clk(clk), .rst(rst), .st_rdy(st_rdy_a), .tr(tr_a), .ts(ts_a),
    .ts_vld(ts_vld_a), .p_cnt(p_cnt_a), .udp_rdy(udp_rdy_a), .addr(addr_a),
    .start(start_a), .payload(payload_a), .drop_cnt(drop_cnt_a),
    .trg_led(trg_led_a), .dbg_state(dbg_state_a)
  );

  ws_logger_stats #(.Nch(1), .Nm(16), .Npr(16), .Nsz(7)) dut_b (
    .clk(clk), .rst(rst), .st_rdy(st_rdy_b), .tr(tr_b), .ts(ts_b),
    .ts_vld(ts_vld_b), .p_cnt(p_cnt_b), .udp_rdy(udp_rdy_b), .addr(addr_b),
    .start(start_b), .payload(payload_b), .drop_cnt(drop_cnt_b),
    .trg_led(trg_led_b), .dbg_state(dbg_state_b)
  );

  // start pulses of instance a, sampled mid-cycle
  always @(negedge clk) if (!rst && start_a) n_start++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic byte_a(input logic [6:0] a, input logic [7:0] exp, input string tag);
    addr_a = a;
    #1;
    chk(tag, 32'(payload_a), 32'(exp));
  endtask

  task automatic byte_b(input logic [6:0] a, input logic [7:0] exp, input string tag);
    addr_b = a;
    #1;
    chk(tag, 32'(payload_b), 32'(exp));
  endtask

  // driver: one measurement on instance a
  task automatic meas(input logic [15:0] t_tr, input logic [15:0] t0, input logic [15:0] t1,
                      input logic [1:0] vld, input logic [31:0] pc);
    tr_a     = t_tr;
    ts_a     = {t1, t0};
    ts_vld_a = vld;
    p_cnt_a  = pc;
    st_rdy_a = 1'b1;
    step();
    st_rdy_a = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    st_rdy_a = 0; tr_a = 0; ts_a = 0; ts_vld_a = 0; p_cnt_a = 0; udp_rdy_a = 1; addr_a = 0;
    st_rdy_b = 0; tr_b = 0; ts_b = 0; ts_vld_b = 0; p_cnt_b = 32'hA5A5A5A5; udp_rdy_b = 1; addr_b = 0;
    step(); step();
    rst = 1'b0;

    // reset state
    chk("rst_start", 32'(start_a), 0);
    chk("rst_trg", 32'(trg_led_a), 0);
    chk("rst_drop", 32'(drop_cnt_a), 0);
    chk("rst_state", 32'(dbg_state_a), 0);
    byte_a(7'd6, 8'h00, "rst_shadow6");
    byte_a(7'd14, 8'h00, "rst_shadow14");

    // miss saturation: 65536 missed edges on instance b
    st_rdy_b = 1'b1;
    repeat (65536) @(posedge clk);
    #1;
    st_rdy_b = 1'b0;
    chk("sat_start", 32'(start_b), 1);
    byte_b(7'd10, 8'hFF, "sat_miss_lo");
    byte_b(7'd11, 8'hFF, "sat_miss_hi");
    byte_b(7'd8, 8'hFF, "sat_min_lo");
    byte_b(7'd6, 8'h00, "sat_max_lo");
    byte_b(7'd0, 8'hA5, "sat_pcnt0");

    // window 1: ch0 jitter 3,2,10,0; ch1 all missed
    meas(16'd100, 16'd103, 16'd0, 2'b01, 32'd1);
    meas(16'd100, 16'd98,  16'd0, 2'b01, 32'd2);
    meas(16'd100, 16'd110, 16'd0, 2'b01, 32'd3);
    chk("w1_no_early_start", 32'(start_a), 0);
    meas(16'd100, 16'd100, 16'd0, 2'b01, 32'h11223344);
    chk("w1_start", 32'(start_a), 1);
    byte_a(7'd0, 8'h44, "w1_pcnt0");
    byte_a(7'd3, 8'h11, "w1_pcnt3");
    byte_a(7'd4, 8'h00, "w1_drop_lo");
    byte_a(7'd6, 8'd10, "w1_max0_lo");
    byte_a(7'd7, 8'h00, "w1_max0_hi");
    byte_a(7'd8, 8'h00, "w1_min0_lo");
    byte_a(7'd10, 8'h00, "w1_miss0_lo");
    byte_a(7'd12, 8'h00, "w1_max1_lo");
    byte_a(7'd14, 8'hFF, "w1_min1_lo");
    byte_a(7'd15, 8'hFF, "w1_min1_hi");
    byte_a(7'd16, 8'd4, "w1_miss1_lo");
    byte_a(7'd17, 8'h00, "w1_miss1_hi");
    byte_a(7'd18, 8'h00, "w1_beyond_psz");
    byte_a(7'd127, 8'h00, "w1_addr_max");
    step();
    chk("w1_start_one_cycle", 32'(start_a), 0);
    chk("w1_trg", 32'(trg_led_a), 1);
    chk("w1_busy", 32'(dbg_state_a), 1);

    // window 2 closes while the sender is busy: dropped
    udp_rdy_a = 1'b0;
    step();
    chk("w2_done", 32'(dbg_state_a), 2);
    repeat (4) meas(16'd0, 16'd50, 16'd7, 2'b11, 32'd2);
    chk("w2_drop", 32'(drop_cnt_a), 1);
    chk("w2_no_start", 32'(start_a), 0);
    byte_a(7'd6, 8'd10, "w2_shadow_kept");
    byte_a(7'd0, 8'h44, "w2_pcnt_kept");
    udp_rdy_a = 1'b1;
    step();
    chk("w2_idle", 32'(dbg_state_a), 0);
    chk("w2_idle_no_start", 32'(start_a), 0);

    // window 3: wrap-around jitter 0xFFEB, drop snapshot 1
    repeat (4) meas(16'hFFF0, 16'h0005, 16'd0, 2'b01, 32'd5);
    chk("w3_start", 32'(start_a), 1);
    byte_a(7'd0, 8'h05, "w3_pcnt0");
    byte_a(7'd4, 8'h01, "w3_drop_lo");
    byte_a(7'd5, 8'h00, "w3_drop_hi");
    byte_a(7'd6, 8'hEB, "w3_max0_lo");
    byte_a(7'd7, 8'hFF, "w3_max0_hi");
    byte_a(7'd8, 8'hEB, "w3_min0_lo");
    step();
    chk("w3_trg", 32'(trg_led_a), 0);
    udp_rdy_a = 1'b0;
    step();
    udp_rdy_a = 1'b1;
    step();
    chk("w3_idle", 32'(dbg_state_a), 0);

    // windows 4 and 5 with the sender not ready: 4 pends, 5 drops
    udp_rdy_a = 1'b0;
    repeat (4) meas(16'd100, 16'd100, 16'd0, 2'b01, 32'd7);
    chk("w4_no_start", 32'(start_a), 0);
    chk("w4_no_drop", 32'(drop_cnt_a), 1);
    repeat (4) meas(16'd100, 16'd120, 16'd0, 2'b01, 32'd8);
    chk("w5_drop", 32'(drop_cnt_a), 2);
    byte_a(7'd0, 8'h07, "w5_pcnt_kept");
    byte_a(7'd6, 8'h00, "w5_max_kept");
    udp_rdy_a = 1'b1;
    #1;
    chk("w4_start", 32'(start_a), 1);
    step();
    chk("w4_trg", 32'(trg_led_a), 1);
    chk("w4_busy", 32'(dbg_state_a), 1);

    // reset one cycle after start
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_start", 32'(start_a), 0);
    chk("mid_rst_trg", 32'(trg_led_a), 0);
    chk("mid_rst_drop", 32'(drop_cnt_a), 0);
    chk("mid_rst_state", 32'(dbg_state_a), 0);
    byte_a(7'd0, 8'h00, "mid_rst_shadow");

    // window 6 after reset: normal frame
    meas(16'd100, 16'd105, 16'd100, 2'b11, 32'd9);
    meas(16'd100, 16'd95,  16'd100, 2'b11, 32'd9);
    meas(16'd100, 16'd100, 16'd100, 2'b11, 32'd9);
    meas(16'd100, 16'd101, 16'd100, 2'b11, 32'd9);
    chk("w6_start", 32'(start_a), 1);
    byte_a(7'd0, 8'h09, "w6_pcnt0");
    byte_a(7'd4, 8'h00, "w6_drop_lo");
    byte_a(7'd6, 8'd5, "w6_max0_lo");
    byte_a(7'd8, 8'h00, "w6_min0_lo");
    byte_a(7'd14, 8'h00, "w6_min1_lo");
    byte_a(7'd15, 8'h00, "w6_min1_hi");
    byte_a(7'd16, 8'h00, "w6_miss1_lo");
    step();
    chk("w6_trg", 32'(trg_led_a), 1);
    step();

    // one start per completed handshake: windows 1, 3, 4 and 6
    chk("start_count", 32'(n_start), 4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
